pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register with a valid/ready handshake, replacing the fixed free-running inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the pipelined CPU.
- Payload is split into two fields:
  - control: write-enables, selects, ops; zeroed on bubble/flush.
  - data: operands, ALU result, PC+4; held, not cleared.
- Supports hazard-unit flush, optional 2-entry skid mode for registered in_ready, and saturating stall/flush counters for performance debug.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_sat_counter.sv | 39 +++
 rtl/pipe_stage_reg.sv | 186 ++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU inter-stage pipeline registers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: skid state encoding, default field widths per stage boundary,
// and bit positions of the architectural write enables in the ctrl field.
package pipe_pkg;

  // Occupancy of the 2-entry skid variant.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // Default field widths for each stage boundary of the CPU.
  localparam int IF_ID_CTRL_W  = 4;   // predecode hints only
  localparam int IF_ID_DATA_W  = 64;  // instr, npc_pc4
  localparam int ID_EX_CTRL_W  = 16;  // rf_we, bus_we, wd_sel, alu op, rf addrs
  localparam int ID_EX_DATA_W  = 96;  // rf_rd1, rf_rd2, npc_pc4
  localparam int EX_MEM_CTRL_W = 16;  // rf_we, bus_we, wd_sel, ld/st op, rf addr
  localparam int EX_MEM_DATA_W = 96;  // rf_rd2, alu_cal, npc_pc4
  localparam int MEM_WB_CTRL_W = 8;   // rf_we, wd_sel, rf addr
  localparam int MEM_WB_DATA_W = 96;  // bus_rdata, alu_cal, npc_pc4

  // Write enables live at fixed offsets so a zeroed ctrl field is a true bubble.
  localparam int RF_WE_BIT  = 0;
  localparam int BUS_WE_BIT = 1;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter for pipeline performance debug.
// Latency: count reflects an inc one cycle after the edge that samples it.
// Backpressure: none; sticks at all-ones, clr has priority over inc.
//
// Ports: clk, rst_n (async, active low), inc (count this cycle),
//        clr (synchronous clear), cnt (current count, W bits).
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and debug counters.
// Latency: 1 cycle from accept to out_*; full throughput in both modes.
// Backpressure: SKID=0 in_ready = ~out_valid | out_ready; SKID=1 in_ready
//               decoded from state flops (low only when both entries full).
//
// Ports: clk, rst_n; in_valid/in_ready/in_ctrl/in_data upstream beat;
//        out_valid/out_ready/out_ctrl/out_data downstream beat; flush kills
//        held beats and any beat accepted this cycle; clr_stats clears
//        stall_cnt (cycles stalled by downstream) and flush_cnt (flushes that
//        discarded a valid beat).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 96,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic accept;
  logic pop;
  logic flush_hit;  // flush discarded at least one valid beat

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  generate
    if (SKID == 0) begin : g_reg
      logic              valid_q, valid_d;
      logic [CTRL_W-1:0] ctrl_q, ctrl_d;
      logic [DATA_W-1:0] data_q, data_d;

      // Combinational path from out_ready keeps streaming at full rate.
      assign in_ready = ~valid_q | out_ready;

      always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush) begin
          valid_d = 1'b0;
          ctrl_d  = '0;
        end else if (accept) begin
          // Covers accept+pop too: new beat replaces the consumed one.
          valid_d = 1'b1;
          ctrl_d  = in_ctrl;
          data_d  = in_data;
        end else if (pop) begin
          valid_d = 1'b0;
          ctrl_d  = '0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          ctrl_q  <= '0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          ctrl_q  <= ctrl_d;
          data_q  <= data_d;
        end
      end

      assign out_valid = valid_q;
      assign out_ctrl  = ctrl_q;
      assign out_data  = data_q;
      assign flush_hit = flush & (valid_q | accept);

    end else begin : g_skid
      skid_state_e       state_q, state_d;
      logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
      logic [DATA_W-1:0] main_data_q, main_data_d;
      logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
      logic [DATA_W-1:0] skid_data_q, skid_data_d;

      // Decoded purely from state flops: no path from out_ready to in_ready.
      assign in_ready = (state_q != ST_TWO);

      always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
          state_d     = ST_EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end else begin
          unique case (state_q)
            ST_EMPTY: begin
              if (accept) begin
                state_d     = ST_ONE;
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
              end
            end
            ST_ONE: begin
              if (accept && pop) begin
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
              end else if (accept) begin
                // Downstream stalled: park the beat, in_ready drops next cycle.
                state_d     = ST_TWO;
                skid_ctrl_d = in_ctrl;
                skid_data_d = in_data;
              end else if (pop) begin
                state_d     = ST_EMPTY;
                main_ctrl_d = '0;
              end
            end
            ST_TWO: begin
              // in_ready is low here, so no accept can arrive.
              if (pop) begin
                state_d     = ST_ONE;
                main_ctrl_d = skid_ctrl_q;
                main_data_d = skid_data_q;
                skid_ctrl_d = '0;
              end
            end
            default: begin
              state_d     = ST_EMPTY;
              main_ctrl_d = '0;
              skid_ctrl_d = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q     <= ST_EMPTY;
          main_ctrl_q <= '0;
          main_data_q <= '0;
          skid_ctrl_q <= '0;
          skid_data_q <= '0;
        end else begin
          state_q     <= state_d;
          main_ctrl_q <= main_ctrl_d;
          main_data_q <= main_data_d;
          skid_ctrl_q <= skid_ctrl_d;
          skid_data_q <= skid_data_d;
        end
      end

      assign out_valid = (state_q != ST_EMPTY);
      assign out_ctrl  = main_ctrl_q;
      assign out_data  = main_data_q;
      assign flush_hit = flush & (out_valid | (state_q == ST_TWO) | accept);
    end
  endgenerate

  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready),
    .clr   (clr_stats),
    .cnt   (stall_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_hit),
    .clr   (clr_stats),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: u0 is the plain register (SKID=0,
// 4-bit counters), u1 the skid variant (SKID=1, 16-bit counters). Both see
// the same inputs; each sequence checks the instance it targets.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_ctrl;
  logic [95:0] in_data;
  logic        flush;
  logic        out_ready;
  logic        clr_stats;

  logic        o0_ir, o0_ov;
  logic [15:0] o0_ctrl;
  logic [95:0] o0_data;
  logic [3:0]  o0_stall, o0_flush;

  logic        o1_ir, o1_ov;
  logic [15:0] o1_ctrl;
  logic [95:0] o1_data;
  logic [15:0] o1_stall, o1_flush;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(96), .SKID(0), .CNT_W(4)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(o0_ir), .in_ctrl(in_ctrl), .in_data(in_data),
    .flush(flush),
    .out_valid(o0_ov), .out_ready(out_ready), .out_ctrl(o0_ctrl), .out_data(o0_data),
    .clr_stats(clr_stats), .stall_cnt(o0_stall), .flush_cnt(o0_flush)
  );

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(96), .SKID(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(o1_ir), .in_ctrl(in_ctrl), .in_data(in_data),
    .flush(flush),
    .out_valid(o1_ov), .out_ready(out_ready), .out_ctrl(o1_ctrl), .out_data(o1_data),
    .clr_stats(clr_stats), .stall_cnt(o1_stall), .flush_cnt(o1_flush)
  );

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle: inputs changed after this sit away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    clr_stats = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst u0 out_valid", {95'd0, o0_ov}, 96'd0);
    chk("rst u0 in_ready",  {95'd0, o0_ir}, 96'd1);
    chk("rst u0 out_ctrl",  {80'd0, o0_ctrl}, 96'd0);
    chk("rst u0 stall_cnt", {92'd0, o0_stall}, 96'd0);
    chk("rst u1 out_valid", {95'd0, o1_ov}, 96'd0);
    chk("rst u1 in_ready",  {95'd0, o1_ir}, 96'd1);
    chk("rst u1 out_ctrl",  {80'd0, o1_ctrl}, 96'd0);
    chk("rst u1 flush_cnt", {80'd0, o1_flush}, 96'd0);
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       exp_ov;
    logic [7:0] exp_od;
    logic       exp_ir;
  } vec_t;

  vec_t bp_tbl[10];

  initial begin
    // SKID=1 backpressure: out_ready low on cycles 3-5. The sender holds beat 4
    // while in_ready is low. Expected outputs are after the cycle's edge.
    bp_tbl[0] = '{1'b1, 8'd1, 1'b1, 1'b1, 8'd1, 1'b1};
    bp_tbl[1] = '{1'b1, 8'd2, 1'b1, 1'b1, 8'd2, 1'b1};
    bp_tbl[2] = '{1'b1, 8'd3, 1'b0, 1'b1, 8'd2, 1'b0};  // -> TWO
    bp_tbl[3] = '{1'b1, 8'd4, 1'b0, 1'b1, 8'd2, 1'b0};
    bp_tbl[4] = '{1'b1, 8'd4, 1'b0, 1'b1, 8'd2, 1'b0};
    bp_tbl[5] = '{1'b1, 8'd4, 1'b1, 1'b1, 8'd3, 1'b1};  // skid drains to main
    bp_tbl[6] = '{1'b1, 8'd4, 1'b1, 1'b1, 8'd4, 1'b1};
    bp_tbl[7] = '{1'b1, 8'd5, 1'b1, 1'b1, 8'd5, 1'b1};
    bp_tbl[8] = '{1'b1, 8'd6, 1'b1, 1'b1, 8'd6, 1'b1};
    bp_tbl[9] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1};

    idle_inputs();
    rst_n = 1'b0;
    #3;

    // ---- Streaming, both modes ----
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      in_valid  = 1'b1;
      in_data   = 96'(i);
      in_ctrl   = 16'(i);
      out_ready = 1'b1;
      tick();
      chk($sformatf("stream u0 valid %0d", i), {95'd0, o0_ov}, 96'd1);
      chk($sformatf("stream u0 data %0d", i), o0_data, 96'(i));
      chk($sformatf("stream u1 valid %0d", i), {95'd0, o1_ov}, 96'd1);
      chk($sformatf("stream u1 data %0d", i), o1_data, 96'(i));
      chk($sformatf("stream u1 ctrl %0d", i), {80'd0, o1_ctrl}, 96'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream u0 drained",  {95'd0, o0_ov}, 96'd0);
    chk("stream u0 ctrl0",    {80'd0, o0_ctrl}, 96'd0);
    chk("stream u1 drained",  {95'd0, o1_ov}, 96'd0);
    chk("stream u1 ctrl0",    {80'd0, o1_ctrl}, 96'd0);
    chk("stream u0 stall",    {92'd0, o0_stall}, 96'd0);
    chk("stream u1 stall",    {80'd0, o1_stall}, 96'd0);

    // ---- Backpressure, SKID=1 (table) ----
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid  = bp_tbl[i].iv;
      in_data   = 96'(bp_tbl[i].d);
      in_ctrl   = 16'(bp_tbl[i].d);
      out_ready = bp_tbl[i].ordy;
      tick();
      chk($sformatf("bp valid c%0d", i + 1), {95'd0, o1_ov}, {95'd0, bp_tbl[i].exp_ov});
      chk($sformatf("bp in_ready c%0d", i + 1), {95'd0, o1_ir}, {95'd0, bp_tbl[i].exp_ir});
      if (bp_tbl[i].exp_ov)
        chk($sformatf("bp data c%0d", i + 1), o1_data, 96'(bp_tbl[i].exp_od));
      else
        chk($sformatf("bp ctrl0 c%0d", i + 1), {80'd0, o1_ctrl}, 96'd0);
    end
    chk("bp stall_cnt", {80'd0, o1_stall}, 96'd3);

    // ---- Flush with full skid stage ----
    do_reset();
    in_valid = 1'b1; in_ctrl = 16'hFFFF; in_data = 96'd1; out_ready = 1'b0;
    tick();
    in_data = 96'd2;
    tick();
    chk("flush2 pre in_ready", {95'd0, o1_ir}, 96'd0);
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush2 out_valid", {95'd0, o1_ov}, 96'd0);
    chk("flush2 out_ctrl",  {80'd0, o1_ctrl}, 96'd0);
    chk("flush2 in_ready",  {95'd0, o1_ir}, 96'd1);
    chk("flush2 flush_cnt", {80'd0, o1_flush}, 96'd1);
    chk("flush2 stall_cnt", {80'd0, o1_stall}, 96'd2);
    // Skid entry must be gone: one new beat, then empty.
    in_valid = 1'b1; in_ctrl = 16'h0001; in_data = 96'd7; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("flush2 after data", o1_data, 96'd7);
    tick();
    chk("flush2 after empty", {95'd0, o1_ov}, 96'd0);

    // ---- Flush plus simultaneous accept, empty stage ----
    do_reset();
    in_valid = 1'b1; in_ctrl = 16'h00A5; in_data = 96'hA5; out_ready = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flushacc u0 valid",  {95'd0, o0_ov}, 96'd0);
    chk("flushacc u0 ctrl",   {80'd0, o0_ctrl}, 96'd0);
    chk("flushacc u0 cnt",    {92'd0, o0_flush}, 96'd1);
    chk("flushacc u1 cnt",    {80'd0, o1_flush}, 96'd1);
    tick();
    chk("flushacc u0 valid2", {95'd0, o0_ov}, 96'd0);
    chk("flushacc u1 valid2", {95'd0, o1_ov}, 96'd0);

    // ---- Counter saturation, CNT_W=4 on u0 ----
    do_reset();
    in_valid = 1'b1; in_ctrl = 16'h0009; in_data = 96'd9; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i >= 15) chk($sformatf("sat stall %0d", i), {92'd0, o0_stall}, 96'd15);
    end
    chk("sat hold data", o0_data, 96'd9);
    chk("sat hold ctrl", {80'd0, o0_ctrl}, 96'd9);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("sat clr wins", {92'd0, o0_stall}, 96'd0);
    tick();
    chk("sat recount", {92'd0, o0_stall}, 96'd1);

    // ---- Async reset mid-stream in TWO ----
    do_reset();
    in_valid = 1'b1; in_ctrl = 16'h0003; in_data = 96'd11; out_ready = 1'b0;
    tick();
    in_data = 96'd12;
    tick();
    in_valid = 1'b0;
    chk("areset pre in_ready", {95'd0, o1_ir}, 96'd0);
    chk("areset pre stall",    {80'd0, o1_stall}, 96'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset u1 out_valid", {95'd0, o1_ov}, 96'd0);
    chk("areset u1 stall",     {80'd0, o1_stall}, 96'd0);
    chk("areset u1 ctrl",      {80'd0, o1_ctrl}, 96'd0);
    chk("areset u0 out_valid", {95'd0, o0_ov}, 96'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("areset post in_ready", {95'd0, o1_ir}, 96'd1);
    chk("areset post valid",    {95'd0, o1_ov}, 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
